// File: rtl/uart_rx_os.sv
// Oversampling UART receiver with majority voting, runtime frame format,
// break/overrun detection and a valid/ready output register.
module uart_rx_os #(
    parameter int MAX_DATA_BITS = 9,
    parameter int OVERSAMPLE    = 16,
    parameter int SYNC_STAGES   = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     os_tick,
    input  logic                     RX,
    input  logic [3:0]               data_bits,
    input  logic                     parity_enable,
    input  logic                     parity_type,
    input  logic                     stop_bits,
    output logic [MAX_DATA_BITS-1:0] rx_data,
    output logic                     valid,
    input  logic                     ready,
    output logic                     parity_error,
    output logic                     frame_error,
    output logic                     break_detect,
    output logic                     overrun_error,
    output logic                     busy
);

    localparam int CW = $clog2(OVERSAMPLE);
    localparam int M  = OVERSAMPLE / 2;
    localparam logic [CW-1:0] S0   = CW'(M - 1);
    localparam logic [CW-1:0] S1   = CW'(M);
    localparam logic [CW-1:0] SD   = CW'(M + 1);
    localparam logic [CW-1:0] LAST = CW'(OVERSAMPLE - 1);
    localparam logic [3:0]    MAXB = 4'(MAX_DATA_BITS);

    typedef enum logic [2:0] {
        IDLE, START, DATA, PARITY, STOP, WAIT_HIGH
    } state_t;

    logic [SYNC_STAGES-1:0]   sync_q;
    state_t                   state_q, state_d;
    logic [CW-1:0]            cnt_q, cnt_d;
    logic [3:0]               bit_q, bit_d;
    logic [3:0]               nbits_q, nbits_d;
    logic                     pen_q, pen_d;
    logic                     ptype_q, ptype_d;
    logic                     two_q, two_d;
    logic                     stop_q, stop_d;
    logic [1:0]               smp_q, smp_d;
    logic [MAX_DATA_BITS-1:0] shift_q, shift_d;
    logic                     perr_q, perr_d;
    logic                     ferr_q, ferr_d;
    logic                     brk_q, brk_d;
    logic [MAX_DATA_BITS-1:0] data_q, data_d;
    logic                     valid_q, valid_d;
    logic                     pe_q, pe_d;
    logic                     fe_q, fe_d;
    logic                     bd_q, bd_d;
    logic                     ovr_q, ovr_d;
    logic                     rxs, maj, decide, wrap, done;

    assign rxs    = sync_q[SYNC_STAGES-1];
    assign maj    = (smp_q[0] & smp_q[1]) | (smp_q[0] & rxs) | (smp_q[1] & rxs);
    assign decide = (cnt_q == SD);
    assign wrap   = (cnt_q == LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q  <= '1;
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            nbits_q <= '0;
            pen_q   <= 1'b0;
            ptype_q <= 1'b0;
            two_q   <= 1'b0;
            stop_q  <= 1'b0;
            smp_q   <= '0;
            shift_q <= '0;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
            brk_q   <= 1'b0;
            data_q  <= '0;
            valid_q <= 1'b0;
            pe_q    <= 1'b0;
            fe_q    <= 1'b0;
            bd_q    <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], RX};
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            nbits_q <= nbits_d;
            pen_q   <= pen_d;
            ptype_q <= ptype_d;
            two_q   <= two_d;
            stop_q  <= stop_d;
            smp_q   <= smp_d;
            shift_q <= shift_d;
            perr_q  <= perr_d;
            ferr_q  <= ferr_d;
            brk_q   <= brk_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            pe_q    <= pe_d;
            fe_q    <= fe_d;
            bd_q    <= bd_d;
            ovr_q   <= ovr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        nbits_d = nbits_q;
        pen_d   = pen_q;
        ptype_d = ptype_q;
        two_d   = two_q;
        stop_d  = stop_q;
        smp_d   = smp_q;
        shift_d = shift_q;
        perr_d  = perr_q;
        ferr_d  = ferr_q;
        brk_d   = brk_q;
        data_d  = data_q;
        valid_d = valid_q;
        pe_d    = pe_q;
        fe_d    = fe_q;
        bd_d    = bd_q;
        ovr_d   = ovr_q;
        done    = 1'b0;

        if (os_tick) begin
            cnt_d = wrap ? '0 : cnt_q + 1'b1;
            if (cnt_q == S0) smp_d[0] = rxs;
            if (cnt_q == S1) smp_d[1] = rxs;
            unique case (state_q)
                IDLE: begin
                    cnt_d = '0;
                    if (!rxs) begin
                        state_d = START;
                        cnt_d   = CW'(1);
                        nbits_d = (data_bits < 4'd5 || data_bits > MAXB) ?
                                  MAXB : data_bits;
                        pen_d   = parity_enable;
                        ptype_d = parity_type;
                        two_d   = stop_bits;
                        stop_d  = 1'b0;
                        bit_d   = '0;
                        shift_d = '0;
                        perr_d  = 1'b0;
                        ferr_d  = 1'b0;
                        brk_d   = 1'b1;
                    end
                end
                START: begin
                    if (decide && maj) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else if (wrap) begin
                        state_d = DATA;
                    end
                end
                DATA: begin
                    if (decide) begin
                        shift_d[bit_q] = maj;
                        if (maj) brk_d = 1'b0;
                    end
                    if (wrap) begin
                        if (bit_q == nbits_q - 4'd1)
                            state_d = pen_q ? PARITY : STOP;
                        else
                            bit_d = bit_q + 4'd1;
                    end
                end
                PARITY: begin
                    // even wants XOR(data, parity) = 0, odd wants 1
                    if (decide) begin
                        perr_d = ((^shift_q) ^ maj) == ptype_q;
                        if (maj) brk_d = 1'b0;
                    end
                    if (wrap) state_d = STOP;
                end
                STOP: begin
                    if (decide) begin
                        if (!maj) ferr_d = 1'b1;
                        else      brk_d  = 1'b0;
                        if (stop_q == two_q) begin
                            done    = 1'b1;
                            cnt_d   = '0;
                            state_d = maj ? IDLE : WAIT_HIGH;
                        end
                    end else if (wrap) begin
                        stop_d = 1'b1;
                    end
                end
                WAIT_HIGH: begin
                    cnt_d = '0;
                    if (rxs) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end

        if (valid_q && ready) begin
            valid_d = 1'b0;
            ovr_d   = 1'b0;
        end
        if (done) begin
            if (!valid_q || ready) begin
                data_d  = shift_q;
                pe_d    = perr_q;
                fe_d    = ferr_d;
                bd_d    = brk_d;
                valid_d = 1'b1;
                ovr_d   = 1'b0;
            end else begin
                ovr_d = 1'b1;
            end
        end
    end

    assign rx_data       = data_q;
    assign valid         = valid_q;
    assign parity_error  = pe_q;
    assign frame_error   = fe_q;
    assign break_detect  = bd_q;
    assign overrun_error = ovr_q;
    assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_os.sv
// Scoreboard bench for uart_rx_os: frames are driven tick-aligned on RX,
// expected words queued at send time and popped on each handshake.
module tb_uart_rx_os;

    typedef struct packed {
        logic [8:0] data;
        logic       pe;
        logic       fe;
        logic       bd;
        logic       ovr;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       os_tick = 1'b0;
    logic       RX = 1'b1;
    logic [3:0] data_bits = 4'd8;
    logic       parity_enable = 1'b0;
    logic       parity_type = 1'b0;
    logic       stop_bits = 1'b0;
    logic [8:0] rx_data;
    logic       valid;
    logic       ready = 1'b1;
    logic       parity_error, frame_error, break_detect;
    logic       overrun_error, busy;

    logic [1:0] div = '0;
    exp_t       q[$];
    int         n_cmp = 0;
    int         n_bad = 0;
    logic       busy_seen = 1'b0;

    uart_rx_os dut (
        .clk(clk), .reset(reset), .os_tick(os_tick), .RX(RX),
        .data_bits(data_bits), .parity_enable(parity_enable),
        .parity_type(parity_type), .stop_bits(stop_bits),
        .rx_data(rx_data), .valid(valid), .ready(ready),
        .parity_error(parity_error), .frame_error(frame_error),
        .break_detect(break_detect), .overrun_error(overrun_error),
        .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        div     <= div + 2'd1;
        os_tick <= (div == 2'd3);
    end

    always @(negedge clk) if (busy) busy_seen = 1'b1;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!reset && valid && ready) begin
            if (q.size() == 0) begin
                chk("unexpected_valid", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("rx_data", 32'(rx_data), 32'(e.data));
                chk("parity_error", 32'(parity_error), 32'(e.pe));
                chk("frame_error", 32'(frame_error), 32'(e.fe));
                chk("break_detect", 32'(break_detect), 32'(e.bd));
                chk("overrun_error", 32'(overrun_error), 32'(e.ovr));
            end
        end
    end

    task automatic ticks(input int n);
        repeat (n) begin
            @(negedge clk);
            while (!os_tick) @(negedge clk);
        end
    endtask

    task automatic hold_bit(input logic v, input bit glitch);
        RX = v;
        if (glitch) begin
            ticks(8);
            RX = ~v;
            ticks(1);
            RX = v;
            ticks(7);
        end else begin
            ticks(16);
        end
    endtask

    task automatic send(input logic [8:0] d, input int nb, input bit pen,
                        input logic pb, input int ns, input bit glitch);
        hold_bit(1'b0, 1'b0);
        for (int i = 0; i < nb; i++) hold_bit(d[i], glitch);
        if (pen) hold_bit(pb, 1'b0);
        for (int i = 0; i < ns; i++) hold_bit(1'b1, 1'b0);
        RX = 1'b1;
        ticks(4);
    endtask

    task automatic expect_word(input logic [8:0] d, input logic pe,
                               input logic fe, input logic bd,
                               input logic ovr);
        exp_t e;
        e.data = d; e.pe = pe; e.fe = fe; e.bd = bd; e.ovr = ovr;
        q.push_back(e);
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 3000 && q.size() != 0; i++) @(negedge clk);
        chk(tag, 32'(q.size()), 32'd0);
    endtask

    initial begin
        repeat (4) @(negedge clk);
        chk("rst_valid", 32'(valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_data", 32'(rx_data), 32'd0);
        reset = 1'b0;
        ticks(4);

        // 8N1 0xA5
        expect_word(9'h0A5, 0, 0, 0, 0);
        send(9'h0A5, 8, 0, 0, 1, 0);
        drain("drain_8n1");

        // 7E1 with wrong then correct parity
        data_bits = 4'd7; parity_enable = 1; parity_type = 1;
        expect_word(9'h035, 1, 0, 0, 0);
        send(9'h035, 7, 1, 1'b1, 1, 0);
        expect_word(9'h035, 0, 0, 0, 0);
        send(9'h035, 7, 1, 1'b0, 1, 0);
        drain("drain_7e1");

        // false start
        busy_seen = 1'b0;
        RX = 1'b0;
        ticks(4);
        RX = 1'b1;
        ticks(32);
        chk("fs_busy_seen", 32'(busy_seen), 32'd1);
        chk("fs_idle", 32'(busy), 32'd0);
        chk("fs_no_valid", 32'(valid), 32'd0);

        // glitch at mid-sample of every data bit
        data_bits = 4'd8; parity_enable = 0; stop_bits = 0;
        expect_word(9'h05A, 0, 0, 0, 0);
        send(9'h05A, 8, 0, 0, 1, 1);
        drain("drain_glitch");

        // overrun: three frames held off, only the first survives
        @(posedge clk); #1 ready = 1'b0;
        expect_word(9'h011, 0, 0, 0, 1);
        send(9'h011, 8, 0, 0, 1, 0);
        send(9'h022, 8, 0, 0, 1, 0);
        send(9'h033, 8, 0, 0, 1, 0);
        chk("ovr_valid", 32'(valid), 32'd1);
        chk("ovr_hold", 32'(rx_data), 32'h011);
        chk("ovr_flag", 32'(overrun_error), 32'd1);
        @(posedge clk); #1 ready = 1'b1;
        drain("drain_ovr");
        repeat (3) @(negedge clk);
        chk("ovr_clr", 32'(overrun_error), 32'd0);
        chk("ovr_valid_drop", 32'(valid), 32'd0);

        // break, 8E2, line low for two frame times
        parity_enable = 1; parity_type = 1; stop_bits = 1;
        expect_word(9'h000, 0, 1, 1, 0);
        RX = 1'b0;
        ticks(24 * 16);
        chk("brk_wait_high", 32'(busy), 32'd1);
        RX = 1'b1;
        ticks(6);
        chk("brk_idle", 32'(busy), 32'd0);
        drain("drain_brk");

        // 9O2 0x1FF, correct odd parity bit is 0
        data_bits = 4'd9; parity_enable = 1; parity_type = 0;
        expect_word(9'h1FF, 0, 0, 0, 0);
        send(9'h1FF, 9, 1, 1'b0, 2, 0);
        drain("drain_9o2");

        // reset mid-frame with a word held
        data_bits = 4'd8; parity_enable = 0; stop_bits = 0;
        @(posedge clk); #1 ready = 1'b0;
        send(9'h03C, 8, 0, 0, 1, 0);
        chk("pre_rst_valid", 32'(valid), 32'd1);
        RX = 1'b0;
        ticks(40);
        reset = 1'b1;
        #1;
        chk("mid_rst_valid", 32'(valid), 32'd0);
        chk("mid_rst_data", 32'(rx_data), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        RX = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        ready = 1'b1;
        ticks(20);
        expect_word(9'h0C3, 0, 0, 0, 0);
        send(9'h0C3, 8, 0, 0, 1, 0);
        drain("drain_post_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
